rgb_filter_ctrl: RTL and testbench
==================================

// Module: rgb_filter_ctrl
// PURPOSE
//  Sequencer and configuration controller for the RGB convolution filter datapath.
//  - Synchronises and debounces the board switches.
//  - Commits a new kernel/output-mode selection only at a vertical-blanking beat, so
//    no visible frame mixes two kernels.
//  - Drives the stall enable of the convolution pipeline.
//  - Delays the sideband signals (hsync/vsync/vde/valid) and the output-mux select by
//    the convolution latency, under valid/ready backpressure.
// PARAMETERS
//  LATENCY      2   register stages inside the convolution datapath; legal range >=1
//  DEBOUNCE     16  consecutive cycles a synchronised switch value must hold before it is accepted
//  CNT_W        $clog2(DEBOUNCE+1)  derived; do not override
// PORTS
//  clk_i         in   1  clock
//  rst_i         in   1  synchronous reset, active-high
//  switch_i      in   3  asynchronous board switches: [2:1] kernel, [0] conv output enable
//  hsync_i       in   1  upstream sideband
//  vsync_i       in   1  upstream sideband
//  vde_i         in   1  upstream sideband
//  valid_i       in   1  upstream beat valid
//  ready_o       out  1  upstream ready
//  hsync_o       out  1  sideband, delayed LATENCY accepted beats
//  vsync_o       out  1  sideband, delayed LATENCY accepted beats
//  vde_o         out  1  sideband, delayed LATENCY accepted beats
//  valid_o       out  1  downstream beat valid
//  ready_i       in   1  downstream ready
//  kernel_sel_o  out  2  committed kernel (kernel_e); sampled by conv input stage
//  pipe_en_o     out  1  register enable for every conv pipeline stage
//  conv_sel_o    out  1  output-mux select (1 = conv result), aligned with valid_o
//  cfg_commit_o  out  1  one-cycle pulse when a new configuration is committed
// BEHAVIOUR
//  Reset (rst_i=1 at clk edge):
//   - all sync, debounce, pipeline and FSM state cleared; state=IDLE;
//     kernel_sel_o=IDENTITY(2'b00).
//   - conv_sel_o, valid_o, hsync_o, vsync_o, vde_o, cfg_commit_o = 0.
//   - ready_o and pipe_en_o forced 0 while rst_i=1.
//  Switch path:
//   - 2-FF synchroniser, then debounce.
//   - Counter resets to 0 on any change of the synced value; it increments while the
//     value is stable.
//   - When the counter reaches DEBOUNCE-1, sw_stable <= synced value; counter saturates.
//  Handshake:
//   - adv = ~rst_i & (ready_i | ~valid_o); ready_o = pipe_en_o = adv (combinational).
//   - Beat accepted when valid_i & ready_o.
//   - When adv=1, every stage shifts; stage0 loads {valid_i,hsync_i,vsync_i,vde_i,conv_en}.
//   - When adv=0, all stages and outputs hold. valid_o must not drop while ready_i=0.
//   - Latency is exactly LATENCY advancing cycles. Bubbles (valid=0) propagate and do not
//     block acceptance while downstream is ready.
//  Commit FSM (ctrl_state_e):
//   - IDLE: if sw_stable != {kernel_sel_o,conv_en} -> PENDING.
//   - PENDING: on an accepted beat with vsync_i=1 & vde_i=0 (blanking):
//     - kernel_sel_o <= sw_stable[2:1] and conv_en <= sw_stable[0] at that clock edge;
//     - cfg_commit_o=1 for the following cycle;
//     - -> HOLD.
//   - PENDING: if sw_stable returns to the committed value before a blanking beat
//     -> IDLE, no commit.
//   - HOLD: stay until an accepted beat with vsync_i=0 -> IDLE. At most one commit per
//     vsync period.
//   - Switch changes while in HOLD are retained in sw_stable and handled after IDLE.
//  Alignment:
//   - conv_en travels in the sideband pipe, so conv_sel_o changes on the same beat where
//     the first post-commit pixel reaches valid_o.
//  Edge cases:
//   - Reset mid-PENDING discards the pending change; after reset the switches re-debounce
//     from zero.
//   - ready_i=0 during the commit beat: the commit happens only when that beat is accepted.
// STRUCTURE
//  Package rgb_filter_pkg contains:
//   - kernel_e {IDENTITY=2'b00, GAUSSIAN, SHARP, SOBEL}
//   - ctrl_state_e {IDLE, PENDING, HOLD}
//   - sideband_t struct {valid, hsync, vsync, vde, conv_en}
//  Sub-module switch_debounce (WIDTH=3, DEBOUNCE): synchroniser plus counter; outputs
//  sw_stable.
//  FSM and the LATENCY-deep sideband_t shift register live in this module.
// TESTING
//  1. Reset, then switch_i=3'b011 held 40 cycles with no vsync beat
//     -> kernel_sel_o stays 00 and cfg_commit_o stays 0.
//  2. switch_i=3'b011 pulsed for 10 cycles (DEBOUNCE=16)
//     -> sw_stable unchanged; FSM stays IDLE.
//  3. switch_i=3'b111 stable mid-frame; next accepted beat vsync=1, vde=0
//     -> kernel_sel_o=11 the following cycle; cfg_commit_o one pulse;
//        conv_sel_o=1 exactly LATENCY accepted beats later.
//  4. Stream of 8 beats with ready_i=0 for cycles 3-5
//     -> valid_o and sidebands held; ready_o=0 during the stall; output order and count
//        preserved; no beat lost or duplicated.
//  5. Continuous stream with ready_i=1
//     -> hsync_o/vsync_o/vde_o equal the inputs delayed by exactly LATENCY=2 cycles.
//  6. rst_i asserted while PENDING
//     -> kernel_sel_o=00, valid_o=0, state=IDLE; no commit follows on the next blanking
//        beat unless the switches re-debounce.

Source files
------------

// File: rtl/rgb_filter_pkg.sv
// Shared types for the RGB filter controller: kernel codes, commit FSM states
// and the sideband record that travels alongside the convolution datapath.
package rgb_filter_pkg;

  localparam int SW_W = 3;

  typedef enum logic [1:0] {
    IDENTITY = 2'b00,
    GAUSSIAN = 2'b01,
    SHARP    = 2'b10,
    SOBEL    = 2'b11
  } kernel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    HOLD    = 2'b10
  } ctrl_state_e;

  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic vde;
    logic conv_en;
  } sideband_t;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability counter. A synchronised value
// is accepted into sw_stable_o only after it has held for DEBOUNCE cycles.
module switch_debounce
  import rgb_filter_pkg::*;
#(
  parameter int WIDTH    = SW_W,
  parameter int DEBOUNCE = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_stable_o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] cand_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Per-bit metastability synchroniser; each switch is an independent async input.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        sync1_reg[gi] <= 1'b0;
        sync2_reg[gi] <= 1'b0;
      end else begin
        sync1_reg[gi] <= sw_i[gi];
        sync2_reg[gi] <= sync1_reg[gi];
      end
    end
  end

  // Restart the count on any change; accept the value once it has held long enough.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= '0;
    end else begin
      cand_reg <= sync2_reg;
      if (sync2_reg != cand_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end else begin
        stable_reg <= cand_reg;
      end
    end
  end

  assign sw_stable_o = stable_reg;

endmodule

// File: rtl/rgb_filter_ctrl.sv
// Configuration sequencer for the RGB convolution filter: debounced switches,
// kernel/mode commit on vertical blanking, pipeline stall enable and the
// LATENCY-deep sideband delay line that keeps sync/valid/mux-select aligned.
module rgb_filter_ctrl
  import rgb_filter_pkg::*;
#(
  parameter int LATENCY  = 2,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] switch_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       vde_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       vde_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [1:0] kernel_sel_o,
  output logic       pipe_en_o,
  output logic       conv_sel_o,
  output logic       cfg_commit_o
);

  logic [2:0]  sw_stable;
  kernel_e     kernel_reg;
  logic        conv_en_reg;
  logic        commit_reg;
  logic        commit;
  ctrl_state_e state_reg;
  ctrl_state_e state_next;
  logic        adv;
  logic        accepted;
  logic        blank_beat;
  logic [2:0]  committed;
  sideband_t   stage_in;
  sideband_t   pipe_reg  [LATENCY];
  sideband_t   pipe_next [LATENCY];

  switch_debounce #(
    .WIDTH    (3),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .sw_i        (switch_i),
    .sw_stable_o (sw_stable)
  );

  // The whole pipe moves when the output slot is empty or being drained.
  assign adv        = ~rst_i & (ready_i | ~valid_o);
  assign ready_o    = adv;
  assign pipe_en_o  = adv;
  assign accepted   = valid_i & adv;
  assign blank_beat = accepted & vsync_i & ~vde_i;
  assign committed  = {kernel_reg, conv_en_reg};

  assign stage_in = '{valid: valid_i, hsync: hsync_i, vsync: vsync_i,
                      vde: vde_i, conv_en: conv_en_reg};

  // Shift network: stage 0 takes the new beat, every later stage takes its predecessor.
  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      assign pipe_next[gi] = stage_in;
    end else begin : g_body
      assign pipe_next[gi] = pipe_reg[gi-1];
    end
  end

  // Sideband delay line; holds completely while the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) pipe_reg[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < LATENCY; i++) pipe_reg[i] <= pipe_next[i];
    end
  end

  assign valid_o    = pipe_reg[LATENCY-1].valid;
  assign hsync_o    = pipe_reg[LATENCY-1].hsync;
  assign vsync_o    = pipe_reg[LATENCY-1].vsync;
  assign vde_o      = pipe_reg[LATENCY-1].vde;
  assign conv_sel_o = pipe_reg[LATENCY-1].conv_en;

  // Commit FSM: wait for a blanking beat, commit once, then wait for vsync to end.
  always_comb begin
    state_next = state_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sw_stable != committed) state_next = PENDING;
      end
      PENDING: begin
        if (sw_stable == committed) begin
          state_next = IDLE;
        end else if (blank_beat) begin
          commit     = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (accepted & ~vsync_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, committed configuration and the one-cycle commit pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= IDLE;
      kernel_reg  <= IDENTITY;
      conv_en_reg <= 1'b0;
      commit_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      commit_reg <= commit;
      if (commit) begin
        kernel_reg  <= kernel_e'(sw_stable[2:1]);
        conv_en_reg <= sw_stable[0];
      end
    end
  end

  assign kernel_sel_o = kernel_reg;
  assign cfg_commit_o = commit_reg;

endmodule

// File: tb/tb_rgb_filter_ctrl.sv
// Directed bench for rgb_filter_ctrl: table-driven sideband/stall vectors plus
// hand-written sequences for debounce, blanking commit and reset corner cases.
module tb_rgb_filter_ctrl;

  localparam int LATENCY  = 2;
  localparam int DEBOUNCE = 16;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [2:0] switch_i;
  logic       hsync_i, vsync_i, vde_i, valid_i, ready_i;
  logic       ready_o, hsync_o, vsync_o, vde_o, valid_o;
  logic [1:0] kernel_sel_o;
  logic       pipe_en_o, conv_sel_o, cfg_commit_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] stim;  // {valid_i, hsync_i, vsync_i, vde_i, ready_i}
    logic [4:0] exp;   // {valid_o, hsync_o, vsync_o, vde_o, ready_o}
  } vec_t;

  vec_t tbl [13];

  rgb_filter_ctrl #(
    .LATENCY  (LATENCY),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .switch_i     (switch_i),
    .hsync_i      (hsync_i),
    .vsync_i      (vsync_i),
    .vde_i        (vde_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .vde_o        (vde_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .kernel_sel_o (kernel_sel_o),
    .pipe_en_o    (pipe_en_o),
    .conv_sel_o   (conv_sel_o),
    .cfg_commit_o (cfg_commit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0; hsync_i = 1'b0; vsync_i = 1'b0; vde_i = 1'b0; ready_i = 1'b1;
    repeat (n) tick();
  endtask

  task automatic beat(input logic h, input logic vs, input logic de);
    valid_i = 1'b1; hsync_i = h; vsync_i = vs; vde_i = de; ready_i = 1'b1;
  endtask

  initial begin : main
    logic [2:0] exp_q[$];
    logic [3:0] held;
    logic [2:0] want;
    int sent;
    int rcvd;

    // Output during row i equals row i-2 inputs (two advancing cycles); rows 8-12 add a stall.
    tbl[0]  = '{5'b11011, 5'b00001};
    tbl[1]  = '{5'b10011, 5'b00001};
    tbl[2]  = '{5'b11101, 5'b11011};
    tbl[3]  = '{5'b00111, 5'b10011};
    tbl[4]  = '{5'b11001, 5'b11101};
    tbl[5]  = '{5'b10111, 5'b00111};
    tbl[6]  = '{5'b01101, 5'b11001};
    tbl[7]  = '{5'b10011, 5'b10111};
    tbl[8]  = '{5'b11010, 5'b01101};
    tbl[9]  = '{5'b00000, 5'b10010};
    tbl[10] = '{5'b00001, 5'b10011};
    tbl[11] = '{5'b00001, 5'b11011};
    tbl[12] = '{5'b00001, 5'b00001};

    // Reset state, with upstream valid and downstream ready both asserted.
    rst_i = 1'b1; switch_i = 3'b000;
    valid_i = 1'b1; hsync_i = 1'b1; vsync_i = 1'b1; vde_i = 1'b1; ready_i = 1'b1;
    tick(); tick();
    chk("rst_ready_o", 8'(ready_o), 8'd0);
    chk("rst_pipe_en", 8'(pipe_en_o), 8'd0);
    chk("rst_kernel", 8'(kernel_sel_o), 8'd0);
    chk("rst_outputs", 8'({valid_o, hsync_o, vsync_o, vde_o, conv_sel_o, cfg_commit_o}), 8'd0);
    rst_i = 1'b0;
    idle(3);

    // Sideband delay and stall behaviour from the vector table.
    for (int i = 0; i < 13; i++) begin
      {valid_i, hsync_i, vsync_i, vde_i, ready_i} = tbl[i].stim;
      #1;
      $display("vec %0d stim=%b out=%b", i, tbl[i].stim, {valid_o, hsync_o, vsync_o, vde_o, ready_o});
      chk($sformatf("vec%0d_out", i), 8'({valid_o, hsync_o, vsync_o, vde_o, ready_o}), 8'(tbl[i].exp));
      chk($sformatf("vec%0d_pipe_en", i), 8'(pipe_en_o), 8'(tbl[i].exp[0]));
      tick();
    end
    idle(3);

    // Eight-beat stream with downstream stalled on cycles 3..5.
    sent = 0; rcvd = 0; held = '0;
    for (int c = 0; c < 24; c++) begin
      ready_i = !(c >= 3 && c <= 5);
      valid_i = (sent < 8);
      {hsync_i, vsync_i, vde_i} = sent[2:0];
      #1;
      if (c == 3) begin
        chk("stall_valid", 8'(valid_o), 8'd1);
        held = {valid_o, hsync_o, vsync_o, vde_o};
      end
      if (c >= 3 && c <= 5) begin
        chk("stall_ready_o", 8'(ready_o), 8'd0);
        chk("stall_hold", 8'({valid_o, hsync_o, vsync_o, vde_o}), 8'(held));
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stream_extra: got beat %b expected none", {hsync_o, vsync_o, vde_o});
        end else begin
          want = exp_q.pop_front();
          $display("stream beat %0d out=%b", rcvd, {hsync_o, vsync_o, vde_o});
          chk("stream_order", 8'({hsync_o, vsync_o, vde_o}), 8'(want));
        end
        rcvd++;
      end
      if (valid_i && ready_o) begin
        exp_q.push_back(sent[2:0]);
        sent++;
      end
      tick();
    end
    chk("stream_sent", 8'(sent), 8'd8);
    chk("stream_rcvd", 8'(rcvd), 8'd8);
    idle(3);

    // A 10-cycle switch glitch must not be accepted; a following blanking beat commits nothing.
    switch_i = 3'b011;
    repeat (10) tick();
    switch_i = 3'b000;
    repeat (3) tick();
    beat(1'b0, 1'b1, 1'b0);
    tick();
    $display("glitch blank beat kernel=%b commit=%b", kernel_sel_o, cfg_commit_o);
    chk("glitch_commit", 8'(cfg_commit_o), 8'd0);
    chk("glitch_kernel", 8'(kernel_sel_o), 8'd0);
    idle(25);

    // Stable switch change without any vsync beat: nothing commits.
    switch_i = 3'b011;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("novsync_kernel", 8'(kernel_sel_o), 8'd0);
      chk("novsync_commit", 8'(cfg_commit_o), 8'd0);
    end

    // Commit on a blanking beat; conv_sel follows LATENCY accepted beats later.
    switch_i = 3'b111;
    idle(25);
    beat(1'b0, 1'b0, 1'b1);
    tick();
    beat(1'b0, 1'b1, 1'b0);
    #1;
    chk("pre_commit_kernel", 8'(kernel_sel_o), 8'd0);
    tick();
    $display("commit beat kernel=%b commit=%b", kernel_sel_o, cfg_commit_o);
    chk("commit_kernel", 8'(kernel_sel_o), 8'd3);
    chk("commit_pulse", 8'(cfg_commit_o), 8'd1);
    chk("commit_conv_old", 8'(conv_sel_o), 8'd0);
    beat(1'b0, 1'b1, 1'b0);
    tick();
    chk("commit_pulse_end", 8'(cfg_commit_o), 8'd0);
    chk("blank_beat_out_valid", 8'(valid_o), 8'd1);
    chk("blank_beat_out_conv", 8'(conv_sel_o), 8'd0);
    beat(1'b0, 1'b0, 1'b1);
    tick();
    chk("first_new_valid", 8'(valid_o), 8'd1);
    chk("first_new_conv", 8'(conv_sel_o), 8'd1);
    chk("hold_no_recommit", 8'(cfg_commit_o), 8'd0);
    idle(3);

    // Reset while PENDING discards the change until the switches re-debounce.
    switch_i = 3'b010;
    idle(25);
    rst_i = 1'b1;
    beat(1'b0, 1'b1, 1'b0);
    #1;
    chk("rst6_ready_o", 8'(ready_o), 8'd0);
    chk("rst6_pipe_en", 8'(pipe_en_o), 8'd0);
    tick();
    chk("rst6_kernel", 8'(kernel_sel_o), 8'd0);
    chk("rst6_valid", 8'(valid_o), 8'd0);
    chk("rst6_conv", 8'(conv_sel_o), 8'd0);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat(1'b0, 1'b1, 1'b0);
      tick();
      $display("post-reset blank beat %0d kernel=%b commit=%b", k, kernel_sel_o, cfg_commit_o);
      chk("rst6_no_commit", 8'(cfg_commit_o), 8'd0);
      chk("rst6_kernel_hold", 8'(kernel_sel_o), 8'd0);
    end
    idle(30);
    beat(1'b0, 1'b1, 1'b0);
    tick();
    $display("re-debounced commit kernel=%b commit=%b", kernel_sel_o, cfg_commit_o);
    chk("redebounce_kernel", 8'(kernel_sel_o), 8'd1);
    chk("redebounce_commit", 8'(cfg_commit_o), 8'd1);
    beat(1'b0, 1'b0, 1'b1);
    tick();
    chk("redebounce_pulse_end", 8'(cfg_commit_o), 8'd0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
